// File: rtl/pipe_control_unit.sv
// pipe_control_unit: control for the 3-stage F/EX/WB RV32 core.
// Decodes the F instruction, registers its control word into EX, resolves
// branches/jumps in EX and stalls fetch while a multi-cycle multiply runs.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   valid_F, opcode_F, funct3_F, funct7_F, csr_F   F-stage instruction fields
//   rs1_EX, rs2_EX              register operands of the EX instruction
//   aluop_EX, alusrc_EX, regsel_EX, regwrite_EX, gpio_we_EX, illegal_EX
//                               EX-stage control word
//   pc_src, stall_F, flush_F    fetch control
module pipe_control_unit #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned MUL_LATENCY  = 3,
    parameter logic [11:0] CSR_SW_ADDR  = 12'hF00,
    parameter logic [11:0] CSR_HEX_ADDR = 12'hF02
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_F,
    input  logic [6:0]      opcode_F,
    input  logic [2:0]      funct3_F,
    input  logic [6:0]      funct7_F,
    input  logic [11:0]     csr_F,
    input  logic [XLEN-1:0] rs1_EX,
    input  logic [XLEN-1:0] rs2_EX,
    output logic [3:0]      aluop_EX,
    output logic            alusrc_EX,
    output logic [1:0]      regsel_EX,
    output logic            regwrite_EX,
    output logic            gpio_we_EX,
    output logic [1:0]      pc_src,
    output logic            stall_F,
    output logic            flush_F,
    output logic            illegal_EX
);

    localparam int unsigned CNT_W = $clog2(MUL_LATENCY + 1);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_SYS  = 7'b1110011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_XOR   = 4'b0010;
    localparam logic [3:0] ALU_ADD   = 4'b0011;
    localparam logic [3:0] ALU_SUB   = 4'b0100;
    localparam logic [3:0] ALU_MUL   = 4'b0101;
    localparam logic [3:0] ALU_MULH  = 4'b0110;
    localparam logic [3:0] ALU_MULHU = 4'b0111;
    localparam logic [3:0] ALU_SLL   = 4'b1000;
    localparam logic [3:0] ALU_SRL   = 4'b1001;
    localparam logic [3:0] ALU_SRA   = 4'b1010;
    localparam logic [3:0] ALU_SLT   = 4'b1100;
    localparam logic [3:0] ALU_PASS  = 4'b1101;
    localparam logic [3:0] ALU_SLTU  = 4'b1110;

    typedef struct packed {
        logic [3:0] aluop;
        logic       alusrc;
        logic [1:0] regsel;
        logic       regwrite;
        logic       gpio_we;
        logic       illegal;
        logic [2:0] funct3;
        logic       is_branch;
        logic       is_jal;
        logic       is_jalr;
    } ctl_t;

    localparam ctl_t BUBBLE = '{ALU_PASS, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0,
                                3'b000, 1'b0, 1'b0, 1'b0};

    typedef enum logic {IDLE, MUL_WAIT} state_t;

    ctl_t             dec;
    ctl_t             ex;
    logic             bad;
    logic             taken;
    logic             br_bad;
    logic             ex_is_mul;
    logic             mul_start;
    state_t           state;
    logic [CNT_W-1:0] cnt;

    // F-stage decode; anything unsupported becomes an illegal-flagged bubble
    always_comb begin
        dec = BUBBLE;
        bad = 1'b0;
        case (opcode_F)
            OP_R: begin
                dec.regwrite = 1'b1;
                case ({funct7_F, funct3_F})
                    10'b0000000_000: dec.aluop = ALU_ADD;
                    10'b0100000_000: dec.aluop = ALU_SUB;
                    10'b0000000_001: dec.aluop = ALU_SLL;
                    10'b0000000_010: dec.aluop = ALU_SLT;
                    10'b0000000_011: dec.aluop = ALU_SLTU;
                    10'b0000000_100: dec.aluop = ALU_XOR;
                    10'b0000000_101: dec.aluop = ALU_SRL;
                    10'b0100000_101: dec.aluop = ALU_SRA;
                    10'b0000000_110: dec.aluop = ALU_OR;
                    10'b0000000_111: dec.aluop = ALU_AND;
                    10'b0000001_000: dec.aluop = ALU_MUL;
                    10'b0000001_001: dec.aluop = ALU_MULH;
                    10'b0000001_011: dec.aluop = ALU_MULHU;
                    default:         bad       = 1'b1;
                endcase
            end
            OP_I: begin
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
                case (funct3_F)
                    3'b000: dec.aluop = ALU_ADD;
                    3'b010: dec.aluop = ALU_SLT;
                    3'b011: dec.aluop = ALU_SLTU;
                    3'b100: dec.aluop = ALU_XOR;
                    3'b110: dec.aluop = ALU_OR;
                    3'b111: dec.aluop = ALU_AND;
                    3'b001: begin
                        if (funct7_F == 7'b0000000) dec.aluop = ALU_SLL;
                        else                        bad       = 1'b1;
                    end
                    default: begin
                        if (funct7_F == 7'b0000000)      dec.aluop = ALU_SRL;
                        else if (funct7_F == 7'b0100000) dec.aluop = ALU_SRA;
                        else                             bad       = 1'b1;
                    end
                endcase
            end
            OP_LUI: begin
                dec.alusrc   = 1'b1;
                dec.regsel   = 2'b01;
                dec.regwrite = 1'b1;
            end
            OP_SYS: begin
                if (funct3_F == 3'b001 && csr_F == CSR_SW_ADDR) begin
                    dec.regsel   = 2'b00;
                    dec.regwrite = 1'b1;
                end else if (funct3_F == 3'b001 && csr_F == CSR_HEX_ADDR) begin
                    dec.gpio_we = 1'b1;
                end else begin
                    bad = 1'b1;
                end
            end
            OP_BR: begin
                // funct3 010/011 pass through and are flagged in EX
                dec.is_branch = 1'b1;
                dec.funct3    = funct3_F;
            end
            OP_JAL: begin
                dec.regsel   = 2'b11;
                dec.regwrite = 1'b1;
                dec.is_jal   = 1'b1;
            end
            OP_JALR: begin
                if (funct3_F == 3'b000) begin
                    dec.regsel   = 2'b11;
                    dec.regwrite = 1'b1;
                    dec.is_jalr  = 1'b1;
                end else begin
                    bad = 1'b1;
                end
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            dec         = BUBBLE;
            dec.illegal = 1'b1;
        end
    end

    // EX control register: hold on stall, bubble on flush or empty F
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex <= BUBBLE;
        end else if (!stall_F) begin
            ex <= (flush_F || !valid_F) ? BUBBLE : dec;
        end
    end

    // EX-stage branch compare
    always_comb begin
        taken = 1'b0;
        case (ex.funct3)
            3'b000:  taken = (rs1_EX == rs2_EX);
            3'b001:  taken = (rs1_EX != rs2_EX);
            3'b100:  taken = ($signed(rs1_EX) <  $signed(rs2_EX));
            3'b101:  taken = ($signed(rs1_EX) >= $signed(rs2_EX));
            3'b110:  taken = (rs1_EX <  rs2_EX);
            3'b111:  taken = (rs1_EX >= rs2_EX);
            default: taken = 1'b0;
        endcase
    end

    assign br_bad = ex.is_branch && (ex.funct3 == 3'b010 || ex.funct3 == 3'b011);

    always_comb begin
        pc_src = 2'b00;
        if (ex.is_jalr)
            pc_src = 2'b10;
        else if (ex.is_jal || (ex.is_branch && taken))
            pc_src = 2'b01;
    end

    assign flush_F = (pc_src != 2'b00);

    // Multiply occupancy: stall every EX cycle of a multiply except the last
    assign ex_is_mul = (ex.aluop == ALU_MUL) || (ex.aluop == ALU_MULH) ||
                       (ex.aluop == ALU_MULHU);
    assign mul_start = (state == IDLE) && ex_is_mul && (MUL_LATENCY > 1);
    assign stall_F   = mul_start || (state == MUL_WAIT && cnt != CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mul_start) begin
                        state <= MUL_WAIT;
                        cnt   <= CNT_W'(MUL_LATENCY - 1);
                    end
                end
                default: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1))
                        state <= IDLE;
                end
            endcase
        end
    end

    assign aluop_EX    = ex.aluop;
    assign alusrc_EX   = ex.alusrc;
    assign regsel_EX   = ex.regsel;
    assign regwrite_EX = ex.regwrite && !stall_F;
    assign gpio_we_EX  = ex.gpio_we;
    assign illegal_EX  = ex.illegal || br_bad;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Directed bench for pipe_control_unit (MUL_LATENCY = 3). Each step presents
// an F instruction, queues the EX-stage outputs expected after the next edge,
// then sets the EX operands and compares.
module tb_pipe_control_unit;

    typedef struct packed {
        logic [3:0] aluop;
        logic       alusrc;
        logic [1:0] regsel;
        logic       regwrite;
        logic       gpio_we;
        logic [1:0] pc_src;
        logic       stall;
        logic       flush;
        logic       illegal;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_F = 1'b0;
    logic [6:0]  opcode_F = 7'd0;
    logic [2:0]  funct3_F = 3'd0;
    logic [6:0]  funct7_F = 7'd0;
    logic [11:0] csr_F = 12'd0;
    logic [31:0] rs1_EX = 32'd0;
    logic [31:0] rs2_EX = 32'd0;
    logic [3:0]  aluop_EX;
    logic        alusrc_EX;
    logic [1:0]  regsel_EX;
    logic        regwrite_EX;
    logic        gpio_we_EX;
    logic [1:0]  pc_src;
    logic        stall_F;
    logic        flush_F;
    logic        illegal_EX;

    int unsigned errors = 0;
    int unsigned checks = 0;
    obs_t        exp_q[$];

    pipe_control_unit #(
        .XLEN(32), .MUL_LATENCY(3), .CSR_SW_ADDR(12'hF00), .CSR_HEX_ADDR(12'hF02)
    ) dut (
        .clk(clk), .rst(rst), .valid_F(valid_F), .opcode_F(opcode_F),
        .funct3_F(funct3_F), .funct7_F(funct7_F), .csr_F(csr_F),
        .rs1_EX(rs1_EX), .rs2_EX(rs2_EX), .aluop_EX(aluop_EX),
        .alusrc_EX(alusrc_EX), .regsel_EX(regsel_EX), .regwrite_EX(regwrite_EX),
        .gpio_we_EX(gpio_we_EX), .pc_src(pc_src), .stall_F(stall_F),
        .flush_F(flush_F), .illegal_EX(illegal_EX)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(input logic [3:0] a, input logic s, input logic [1:0] r,
                                input logic rw, input logic gw, input logic [1:0] pc,
                                input logic st, input logic fl, input logic il);
        return {a, s, r, rw, gw, pc, st, fl, il};
    endfunction

    obs_t BUB;

    task automatic present(input logic v, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [11:0] csr);
        valid_F  = v;
        opcode_F = op;
        funct3_F = f3;
        funct7_F = f7;
        csr_F    = csr;
    endtask

    task automatic check(input string tag);
        obs_t obs;
        obs_t e;
        obs = {aluop_EX, alusrc_EX, regsel_EX, regwrite_EX, gpio_we_EX,
               pc_src, stall_F, flush_F, illegal_EX};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s scoreboard empty, observed=%h", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    // Queue the expectation, cross the edge, drive EX operands, then compare
    task automatic step(input string tag, input logic [31:0] r1, input logic [31:0] r2,
                        input obs_t e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        rs1_EX = r1;
        rs2_EX = r2;
        #1;
        check(tag);
    endtask

    localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LUI = 7'b0110111;
    localparam logic [6:0] SYS = 7'b1110011, BR = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111, JALR = 7'b1100111;
    localparam logic [6:0] M = 7'b0000001;

    initial begin
        BUB = mk(4'hD, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(BUB);
        check("reset");
        rst = 1'b0;

        present(1, R, 3'b000, 7'h00, 12'h0);
        step("add", 0, 0, mk(4'h3, 0, 2'b10, 1, 0, 2'b00, 0, 0, 0));
        present(1, R, 3'b000, 7'h20, 12'h0);
        step("sub", 0, 0, mk(4'h4, 0, 2'b10, 1, 0, 2'b00, 0, 0, 0));

        present(1, BR, 3'b000, 7'h00, 12'h0);
        step("beq_taken", 5, 5, mk(4'hD, 0, 2'b10, 0, 0, 2'b01, 0, 1, 0));
        present(1, R, 3'b000, 7'h00, 12'h0);
        step("beq_flushed", 0, 0, BUB);
        present(1, BR, 3'b001, 7'h00, 12'h0);
        step("bne_not_taken", 5, 5, BUB);
        present(1, BR, 3'b100, 7'h00, 12'h0);
        step("blt_taken", 32'hFFFF_FFFF, 1, mk(4'hD, 0, 2'b10, 0, 0, 2'b01, 0, 1, 0));
        present(1, BR, 3'b110, 7'h00, 12'h0);
        step("blt_flushed", 0, 0, BUB);
        present(1, BR, 3'b110, 7'h00, 12'h0);
        step("bltu_not_taken", 32'hFFFF_FFFF, 1, BUB);
        present(1, BR, 3'b111, 7'h00, 12'h0);
        step("bgeu_taken", 32'hFFFF_FFFF, 1, mk(4'hD, 0, 2'b10, 0, 0, 2'b01, 0, 1, 0));
        present(0, R, 3'b000, 7'h00, 12'h0);
        step("bgeu_flushed", 0, 0, BUB);
        present(1, BR, 3'b010, 7'h00, 12'h0);
        step("br_f3_010", 3, 3, mk(4'hD, 0, 2'b10, 0, 0, 2'b00, 0, 0, 1));

        present(1, R, 3'b000, M, 12'h0);
        step("mul_c1", 0, 0, mk(4'h5, 0, 2'b10, 0, 0, 2'b00, 1, 0, 0));
        present(1, R, 3'b000, 7'h00, 12'h0);
        step("mul_c2", 0, 0, mk(4'h5, 0, 2'b10, 0, 0, 2'b00, 1, 0, 0));
        step("mul_c3", 0, 0, mk(4'h5, 0, 2'b10, 1, 0, 2'b00, 0, 0, 0));
        step("add_after_mul", 0, 0, mk(4'h3, 0, 2'b10, 1, 0, 2'b00, 0, 0, 0));

        present(1, R, 3'b000, M, 12'h0);
        step("b2b_mul_c1", 0, 0, mk(4'h5, 0, 2'b10, 0, 0, 2'b00, 1, 0, 0));
        present(1, R, 3'b011, M, 12'h0);
        step("b2b_mul_c2", 0, 0, mk(4'h5, 0, 2'b10, 0, 0, 2'b00, 1, 0, 0));
        step("b2b_mul_c3", 0, 0, mk(4'h5, 0, 2'b10, 1, 0, 2'b00, 0, 0, 0));
        step("b2b_mulhu_c1", 0, 0, mk(4'h7, 0, 2'b10, 0, 0, 2'b00, 1, 0, 0));
        present(0, R, 3'b000, 7'h00, 12'h0);
        step("b2b_mulhu_c2", 0, 0, mk(4'h7, 0, 2'b10, 0, 0, 2'b00, 1, 0, 0));
        step("b2b_mulhu_c3", 0, 0, mk(4'h7, 0, 2'b10, 1, 0, 2'b00, 0, 0, 0));
        step("b2b_drain", 0, 0, BUB);

        present(1, SYS, 3'b001, 7'h00, 12'hF02);
        step("csr_hex", 0, 0, mk(4'hD, 0, 2'b10, 0, 1, 2'b00, 0, 0, 0));
        present(1, SYS, 3'b001, 7'h00, 12'hF00);
        step("csr_sw", 0, 0, mk(4'hD, 0, 2'b00, 1, 0, 2'b00, 0, 0, 0));
        present(1, SYS, 3'b001, 7'h00, 12'h123);
        step("csr_bad", 0, 0, mk(4'hD, 0, 2'b10, 0, 0, 2'b00, 0, 0, 1));
        present(1, I, 3'b101, 7'h20, 12'h0);
        step("srai", 0, 0, mk(4'hA, 1, 2'b10, 1, 0, 2'b00, 0, 0, 0));
        present(1, LUI, 3'b000, 7'h00, 12'h0);
        step("lui", 0, 0, mk(4'hD, 1, 2'b01, 1, 0, 2'b00, 0, 0, 0));
        present(1, R, 3'b000, 7'h02, 12'h0);
        step("r_bad_funct7", 0, 0, mk(4'hD, 0, 2'b10, 0, 0, 2'b00, 0, 0, 1));

        present(1, JAL, 3'b000, 7'h00, 12'h0);
        step("jal", 0, 0, mk(4'hD, 0, 2'b11, 1, 0, 2'b01, 0, 1, 0));
        present(1, JALR, 3'b000, 7'h00, 12'h0);
        step("jal_flushed", 0, 0, BUB);
        step("jalr", 0, 0, mk(4'hD, 0, 2'b11, 1, 0, 2'b10, 0, 1, 0));
        present(0, R, 3'b000, 7'h00, 12'h0);
        step("jalr_flushed", 0, 0, BUB);

        present(1, R, 3'b000, M, 12'h0);
        step("rmul_c1", 0, 0, mk(4'h5, 0, 2'b10, 0, 0, 2'b00, 1, 0, 0));
        present(1, R, 3'b000, 7'h00, 12'h0);
        step("rmul_c2", 0, 0, mk(4'h5, 0, 2'b10, 0, 0, 2'b00, 1, 0, 0));
        rst = 1'b1;
        #1;
        exp_q.push_back(BUB);
        check("rst_mid_mul");
        step("rst_held", 0, 0, BUB);
        rst = 1'b0;
        step("add_after_rst", 0, 0, mk(4'h3, 0, 2'b10, 1, 0, 2'b00, 0, 0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
